// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default frame constants
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset value
// Ports: CLKIN clock, RESET async active-high, d async input, q synchronized output.
`timescale 1ns/1ps
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLKIN,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - oversampled UART receive deframer with valid/ready output
// Ports: CLKIN clock, RESET async active-high, baud oversampling strobe, rx serial line,
//        data/valid/ready byte handshake, frame_err and overrun one-cycle pulses.
`timescale 1ns/1ps
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic                 baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rxs;

    rx_state_t             state, state_nxt;
    logic [TICK_W-1:0]     tick_cnt, tick_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0]  shreg, shreg_nxt;
    logic                  byte_done;
    logic                  stop_bad;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .d     (rx),
        .q     (rxs)
    );

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        if (baud) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nxt = START;
                        tick_nxt  = '0;
                    end
                end
                START: begin
                    // Re-check the start bit at its centre; a high here was a glitch.
                    if (tick_cnt == HALF_LAST) begin
                        if (!rxs) begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    // Counter restarted at the start-bit centre, so its wrap lands mid-bit.
                    if (tick_cnt == FULL_LAST) begin
                        tick_nxt  = '0;
                        shreg_nxt = {rxs, shreg[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_nxt  = '0;
                        byte_done = rxs;
                        stop_bad  = !rxs;
                        state_nxt = WAIT_IDLE;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // Holding here during a break keeps it to a single frame_err.
                    if (rxs) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            frame_err <= stop_bad;
            overrun   <= 1'b0;
            if (byte_done) begin
                // A byte accepted on this same edge frees the slot, so no overrun.
                data    <= shreg;
                valid   <= 1'b1;
                overrun <= valid && !ready;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed self-checking bench for uart_rx_deframer
`timescale 1ns/1ps
module tb_uart_rx_deframer;

    logic       CLKIN = 1'b0;
    logic       RESET = 1'b1;
    logic       baud  = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int pc    = 0;
    int vhi_cnt = 0, rise_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, rise_pc = 0;
    logic valid_d = 1'b0;
    int t_start = 0;
    int r0, f0, o0, v0;

    uart_rx_deframer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .CLKIN     (CLKIN),
        .RESET     (RESET),
        .baud      (baud),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 CLKIN = ~CLKIN;

    always @(posedge CLKIN) pc <= pc + 1;

    // One tick every 4 clocks, phase tied to the posedge count.
    always @(negedge CLKIN) baud = ((pc % 4) == 0);

    always @(negedge CLKIN) begin
        if (!RESET) begin
            if (valid) vhi_cnt = vhi_cnt + 1;
            if (valid && !valid_d) begin
                rise_cnt = rise_cnt + 1;
                rise_pc  = pc;
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (overrun) ovr_cnt = ovr_cnt + 1;
        end
        valid_d = valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge CLKIN);
    endtask

    // Start the frame two clocks before a baud-high drive so detection lands on a fixed edge.
    task automatic align();
        do @(negedge CLKIN); while (((pc + 2) % 4) != 0);
        t_start = pc;
    endtask

    task automatic send_now(input logic [7:0] v, input logic stop);
        rx = 1'b0;
        hold(64);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            hold(64);
        end
        rx = stop;
        hold(64);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop);
        align();
        send_now(v, stop);
    endtask

    task automatic snap();
        r0 = rise_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        v0 = vhi_cnt;
    endtask

    initial begin
        hold(5);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        RESET = 1'b0;
        hold(10);

        // 0xA5, ready high: 611-clock latency from start edge with this baud phase
        ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        hold(4);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_latency", 32'(rise_pc - t_start), 32'd611);
        chk("a5_valid_cycles", 32'(vhi_cnt - v0), 32'd1);
        chk("a5_rises", 32'(rise_cnt - r0), 32'd1);
        chk("a5_ferr", 32'(ferr_cnt - f0), 32'd0);
        hold(128);

        // 3-tick low glitch, then a clean frame
        snap();
        @(negedge CLKIN);
        rx = 1'b0;
        hold(12);
        rx = 1'b1;
        hold(128);
        chk("glitch_rises", 32'(rise_cnt - r0), 32'd0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        send_frame(8'hC3, 1'b1);
        hold(8);
        chk("post_glitch_data", 32'(data), 32'hC3);
        hold(128);

        // bad stop bit, then a 40-bit break, then 0x81
        snap();
        send_frame(8'h3C, 1'b0);
        hold(128);
        chk("stop_low_ferr", 32'(ferr_cnt - f0), 32'd1);
        chk("stop_low_rises", 32'(rise_cnt - r0), 32'd0);
        snap();
        @(negedge CLKIN);
        rx = 1'b0;
        hold(40 * 64);
        rx = 1'b1;
        hold(128);
        chk("break_ferr", 32'(ferr_cnt - f0), 32'd1);
        snap();
        send_frame(8'h81, 1'b1);
        hold(8);
        chk("post_break_data", 32'(data), 32'h81);
        chk("post_break_rises", 32'(rise_cnt - r0), 32'd1);
        hold(128);

        // back to back with ready low: overrun
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        hold(8);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_data", 32'(data), 32'h22);
        chk("ovr_valid_held", 32'(valid), 32'd1);
        ready = 1'b1;
        hold(1);
        chk("ovr_valid_clear", 32'(valid), 32'd0);
        hold(128);

        // acceptance on the exact completion edge of the second byte
        ready = 1'b0;
        snap();
        send_frame(8'h33, 1'b1);
        align();
        fork
            send_now(8'h44, 1'b1);
            begin
                hold(610);
                chk("same_pre_data", 32'(data), 32'h33);
                ready = 1'b1;
                hold(1);
                ready = 1'b0;
                chk("same_post_data", 32'(data), 32'h44);
                chk("same_post_valid", 32'(valid), 32'd1);
            end
        join
        hold(16);
        chk("same_no_ovr", 32'(ovr_cnt - o0), 32'd0);
        ready = 1'b1;
        hold(128);

        // reset during data bit 4 of 0xFF
        snap();
        align();
        fork
            send_now(8'hFF, 1'b1);
            begin
                hold(64 * 5 + 32);
                RESET = 1'b1;
                #1;
                chk("mid_rst_valid", 32'(valid), 32'd0);
                chk("mid_rst_data", 32'(data), 32'd0);
                chk("mid_rst_ferr", 32'(frame_err), 32'd0);
                chk("mid_rst_ovr", 32'(overrun), 32'd0);
                hold(8);
                RESET = 1'b0;
            end
        join
        hold(128);
        chk("rst_frame_rises", 32'(rise_cnt - r0), 32'd0);
        chk("rst_frame_ferr", 32'(ferr_cnt - f0), 32'd0);
        snap();
        send_frame(8'h5A, 1'b1);
        hold(8);
        chk("post_rst_data", 32'(data), 32'h5A);
        chk("post_rst_rises", 32'(rise_cnt - r0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
